// File: rtl/fir_sched_pkg.sv
// Shared types, default sizing and the default high-pass coefficient table for the
// time-multiplexed FIR MAC scheduler. Optional build macro: SYMMETRIC_FOLD_EN.
package fir_sched_pkg;

  localparam int unsigned FIR_N           = 51;
  localparam int unsigned FIR_DATA_WIDTH  = 16;
  localparam int unsigned FIR_COEFF_WIDTH = 16;
  localparam int unsigned FIR_ACC_WIDTH   = 39;
  localparam int unsigned FIR_SHIFT       = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } state_e;

  // Default HPF tap value, indexed by distance from the centre tap so the table stays
  // symmetric for any odd tap count. The 51-tap table sums to -2 with centre 29480.
  function automatic int hpf_default(input int unsigned idx, input int unsigned n);
    int unsigned c;
    int unsigned d;
    c = (n - 1) / 2;
    d = (idx > c) ? (idx - c) : (c - idx);
    case (d)
      0:       return 29480;
      1:       return -3300;
      2:       return -2975;
      3:       return -2560;
      4:       return -2150;
      5:       return -1700;
      6:       return -1250;
      7:       return -800;
      8:       return -420;
      9:       return -120;
      10:      return 0;
      11:      return 36;
      12:      return 72;
      13:      return 98;
      14:      return 108;
      15:      return 104;
      16:      return 90;
      17:      return 68;
      18:      return 44;
      19:      return 20;
      20:      return 0;
      21:      return -14;
      22:      return -28;
      23:      return -30;
      24:      return -22;
      25:      return -12;
      default: return 0;
    endcase
  endfunction

  // (a - b) mod n for a < n, b < n.
  function automatic int unsigned mod_sub(input int unsigned a, input int unsigned b,
                                          input int unsigned n);
    return (a >= b) ? (a - b) : (a + n - b);
  endfunction

endpackage

// File: rtl/fir_coef_ram.sv
// Runtime-writable coefficient register file. Reset loads the default HPF table.
// With SYMMETRIC_FOLD_EN defined, every accepted write also lands on the mirror tap.
module fir_coef_ram
  import fir_sched_pkg::*;
#(
  parameter int unsigned N           = FIR_N,
  parameter int unsigned COEFF_WIDTH = FIR_COEFF_WIDTH,
  localparam int unsigned AW         = $clog2(N)
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_we,
  input  logic [AW-1:0]                 i_addr,
  input  logic signed [COEFF_WIDTH-1:0] i_wdata,
  input  logic                          i_allow,
  input  logic [AW-1:0]                 i_raddr,
  output logic signed [COEFF_WIDTH-1:0] o_rdata,
  output logic                          o_err
);

  logic signed [COEFF_WIDTH-1:0] r_coef [N];
  logic                          r_err;
  logic                          w_in_range;
  logic                          w_accept;

  assign w_in_range = (i_addr < AW'(N));
  assign w_accept   = i_we && i_allow && w_in_range;

`ifdef SYMMETRIC_FOLD_EN
  logic [AW-1:0] w_mirror;
  assign w_mirror = AW'(N - 1) - i_addr;
`endif

  // Coefficient storage: default table on reset, guarded writes, one-cycle reject pulse.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < int'(N); i++) begin
        r_coef[i] <= COEFF_WIDTH'(hpf_default(i, N));
      end
      r_err <= 1'b0;
    end else begin
      r_err <= i_we && !w_accept;
      if (w_accept) begin
        r_coef[i_addr] <= i_wdata;
`ifdef SYMMETRIC_FOLD_EN
        r_coef[w_mirror] <= i_wdata;
`endif
      end
    end
  end

  assign o_rdata = r_coef[i_raddr];
  assign o_err   = r_err;

endmodule

// File: rtl/fir_mac_scheduler.sv
// Time-multiplexed FIR controller: one multiplier and one accumulator walk all taps
// over a circular sample history. Optional build macro: SYMMETRIC_FOLD_EN folds
// symmetric tap pairs through a pre-adder, halving the MAC phase.
module fir_mac_scheduler
  import fir_sched_pkg::*;
#(
  parameter int unsigned N           = FIR_N,
  parameter int unsigned DATA_WIDTH  = FIR_DATA_WIDTH,
  parameter int unsigned COEFF_WIDTH = FIR_COEFF_WIDTH,
  parameter int unsigned ACC_WIDTH   = FIR_ACC_WIDTH,
  parameter int unsigned SHIFT       = FIR_SHIFT
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic signed [DATA_WIDTH-1:0]  s_data,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic signed [ACC_WIDTH-1:0]   m_data,
  input  logic                          coef_we,
  input  logic [$clog2(N)-1:0]          coef_addr,
  input  logic signed [COEFF_WIDTH-1:0] coef_wdata,
  output logic                          coef_err,
  output logic                          busy
);

  localparam int unsigned AW  = $clog2(N);
  localparam int unsigned CTR = (N - 1) / 2;
`ifdef SYMMETRIC_FOLD_EN
  localparam int unsigned SW     = DATA_WIDTH + 1;
  localparam int unsigned LAST_K = CTR;
`else
  localparam int unsigned SW     = DATA_WIDTH;
  localparam int unsigned LAST_K = N - 1;
`endif
  localparam int unsigned PW = SW + COEFF_WIDTH;

  state_e                        r_state;
  logic                          r_s_ready;
  logic                          r_m_valid;
  logic                          r_busy;
  logic signed [ACC_WIDTH-1:0]   r_m_data;
  logic signed [ACC_WIDTH-1:0]   r_acc;
  logic [AW-1:0]                 r_wr_ptr;
  logic [AW-1:0]                 r_k;
  logic signed [DATA_WIDTH-1:0]  r_hist [N];

  logic                          w_s_hs;
  logic                          w_coef_allow;
  logic                          w_last;
  logic [AW-1:0]                 w_idx_a;
  logic signed [DATA_WIDTH-1:0]  w_hist_a;
  logic signed [SW-1:0]          w_samp;
  logic signed [COEFF_WIDTH-1:0] w_coef;
  logic signed [PW-1:0]          w_coef_x;
  logic signed [PW-1:0]          w_samp_x;
  logic signed [PW-1:0]          w_prod;
  logic signed [ACC_WIDTH-1:0]   w_acc_nxt;
  logic signed [ACC_WIDTH-1:0]   w_out_val;

  assign w_s_hs       = s_valid && r_s_ready;
  // A coefficient write must not race a sample that is about to start a MAC pass.
  assign w_coef_allow = (r_state == IDLE) && !w_s_hs;
  assign w_last       = (r_k == AW'(LAST_K));

  // Newest sample sits at wr_ptr; tap k looks k samples back, wrapping below zero.
  assign w_idx_a  = AW'(mod_sub(32'(r_wr_ptr), 32'(r_k), N));
  assign w_hist_a = r_hist[w_idx_a];

`ifdef SYMMETRIC_FOLD_EN
  logic [AW-1:0]                w_idx_b;
  logic signed [DATA_WIDTH-1:0] w_hist_b;
  assign w_idx_b  = AW'(mod_sub(32'(r_wr_ptr), (N - 1) - 32'(r_k), N));
  assign w_hist_b = r_hist[w_idx_b];
  // Centre tap has no partner; all other passes pre-add the mirrored pair.
  assign w_samp   = (r_k == AW'(CTR)) ? SW'(w_hist_a) : SW'(w_hist_a) + SW'(w_hist_b);
`else
  assign w_samp   = w_hist_a;
`endif

  assign w_coef_x  = PW'(w_coef);
  assign w_samp_x  = PW'(w_samp);
  assign w_prod    = w_coef_x * w_samp_x;
  assign w_acc_nxt = r_acc + ACC_WIDTH'(w_prod);
  assign w_out_val = w_acc_nxt >>> SHIFT;

  fir_coef_ram #(
    .N           (N),
    .COEFF_WIDTH (COEFF_WIDTH)
  ) u_coef_ram (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_we    (coef_we),
    .i_addr  (coef_addr),
    .i_wdata (coef_wdata),
    .i_allow (w_coef_allow),
    .i_raddr (r_k),
    .o_rdata (w_coef),
    .o_err   (coef_err)
  );

  // Scheduler FSM: accept sample, run one tap per cycle, hold result until taken.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_s_ready <= 1'b0;
      r_m_valid <= 1'b0;
      r_busy    <= 1'b0;
      r_m_data  <= '0;
      r_acc     <= '0;
      r_wr_ptr  <= '0;
      r_k       <= '0;
      for (int i = 0; i < int'(N); i++) begin
        r_hist[i] <= '0;
      end
    end else begin
      case (r_state)
        IDLE: begin
          r_s_ready <= 1'b1;
          if (w_s_hs) begin
            r_hist[r_wr_ptr] <= s_data;
            r_acc            <= '0;
            r_k              <= '0;
            r_s_ready        <= 1'b0;
            r_busy           <= 1'b1;
            r_state          <= MAC;
          end
        end
        MAC: begin
          r_acc <= w_acc_nxt;
          if (w_last) begin
            r_m_data  <= w_out_val;
            r_m_valid <= 1'b1;
            r_k       <= '0;
            r_wr_ptr  <= (r_wr_ptr == AW'(N - 1)) ? '0 : r_wr_ptr + AW'(1);
            r_state   <= OUT;
          end else begin
            r_k <= r_k + AW'(1);
          end
        end
        OUT: begin
          if (m_ready) begin
            r_m_valid <= 1'b0;
            r_busy    <= 1'b0;
            r_s_ready <= 1'b1;
            r_state   <= IDLE;
          end
        end
        default: begin
          r_state   <= IDLE;
          r_s_ready <= 1'b0;
          r_m_valid <= 1'b0;
          r_busy    <= 1'b0;
        end
      endcase
    end
  end

  assign s_ready = r_s_ready;
  assign m_valid = r_m_valid;
  assign m_data  = r_m_data;
  assign busy    = r_busy;

endmodule

// File: tb/tb_fir_mac_scheduler.sv
// Directed self-checking bench for fir_mac_scheduler. Honours SYMMETRIC_FOLD_EN for latency.
module tb_fir_mac_scheduler;

  localparam int NT = 51;
`ifdef SYMMETRIC_FOLD_EN
  localparam int LAT = 27;
`else
  localparam int LAT = 52;
`endif
  // Taps 0..25 of the default table; taps 26..50 mirror them.
  localparam int HALF [26] = '{-12, -22, -30, -28, -14, 0, 20, 44, 68, 90, 104, 108, 98, 72,
                               36, 0, -120, -420, -800, -1250, -1700, -2150, -2560, -2975,
                               -3300, 29480};

  logic               clk;
  logic               rst;
  logic               s_valid;
  logic               s_ready;
  logic signed [15:0] s_data;
  logic               m_valid;
  logic               m_ready;
  logic signed [38:0] m_data;
  logic               coef_we;
  logic [5:0]         coef_addr;
  logic signed [15:0] coef_wdata;
  logic               coef_err;
  logic               busy;

  int     n_tests = 0;
  int     n_fail  = 0;
  int     cyc     = 0;
  int     hs_cyc  = 0;
  longint got;
  longint held;
  longint h_tb [NT];
  longint xh   [NT];

  fir_mac_scheduler dut (
    .clk        (clk),
    .rst        (rst),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .coef_we    (coef_we),
    .coef_addr  (coef_addr),
    .coef_wdata (coef_wdata),
    .coef_err   (coef_err),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not complete, n_fail=%0d", n_fail);
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input longint obs, input longint exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int k = 0; k < NT; k++) begin
      h_tb[k] = HALF[(k <= 25) ? k : 50 - k];
      xh[k]   = 0;
    end
  endtask

  // Golden convolution over the bench's own history, floored by the 15-bit shift.
  function automatic longint model_out();
    longint sum;
    sum = 0;
    for (int k = 0; k < NT; k++) sum += h_tb[k] * xh[k];
    return sum >>> 15;
  endfunction

  task automatic send(input logic signed [15:0] x);
    int n;
    n = 0;
    s_valid = 1'b1;
    s_data  = x;
    while (s_ready !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    check("s_ready_wait", longint'(s_ready), 1);
    hs_cyc = cyc;
    tick();
    s_valid = 1'b0;
    for (int k = NT - 1; k > 0; k--) xh[k] = xh[k-1];
    xh[0] = longint'(x);
  endtask

  task automatic wait_out(input string tag, output longint res);
    int n;
    n = 0;
    while (m_valid !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    check({tag, "_valid"}, longint'(m_valid), 1);
    check({tag, "_lat"}, longint'(cyc - hs_cyc), LAT);
    check({tag, "_data"}, longint'($signed(m_data)), model_out());
    res = longint'($signed(m_data));
    if (m_ready) tick();
  endtask

  initial begin
    rst        = 1'b0;
    s_valid    = 1'b0;
    s_data     = '0;
    m_ready    = 1'b1;
    coef_we    = 1'b0;
    coef_addr  = '0;
    coef_wdata = '0;
    model_reset();

    // Reset values
    repeat (3) tick();
    check("rst_s_ready", longint'(s_ready), 0);
    check("rst_m_valid", longint'(m_valid), 0);
    check("rst_m_data", longint'($signed(m_data)), 0);
    check("rst_coef_err", longint'(coef_err), 0);
    check("rst_busy", longint'(busy), 0);
    rst = 1'b1;
    tick();
    tick();
    check("idle_s_ready", longint'(s_ready), 1);
    check("idle_busy", longint'(busy), 0);

    // Impulse: output k is h[k] >>> 1
    for (int i = 0; i < NT; i++) begin
      send((i == 0) ? 16'sd16384 : 16'sd0);
      wait_out($sformatf("imp%0d", i), got);
      if (i == 0)  check("imp_first", got, -6);
      if (i == 25) check("imp_centre", got, 14740);
      if (i == 50) check("imp_last", got, -6);
    end

    // DC: full window of 1000 gives -2000 >>> 15 = -1
    for (int i = 0; i < 60; i++) begin
      send(16'sd1000);
      wait_out($sformatf("dc%0d", i), got);
      if (i >= 50) check("dc_level", got, -1);
    end

    // Backpressure: hold OUT for 10 cycles with a pending sample
    m_ready = 1'b0;
    send(16'sd5000);
    wait_out("bp_first", held);
    s_valid = 1'b1;
    s_data  = 16'sd7000;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_m_valid", longint'(m_valid), 1);
      check("bp_m_data", longint'($signed(m_data)), held);
      check("bp_s_ready", longint'(s_ready), 0);
    end
    m_ready = 1'b1;
    tick();
    check("bp_released", longint'(m_valid), 0);
    check("bp_s_ready_after", longint'(s_ready), 1);
    send(16'sd7000);
    wait_out("bp_second", got);

    // Write coincident with a sample handshake is rejected
    coef_we    = 1'b1;
    coef_addr  = 6'd3;
    coef_wdata = 16'sd999;
    send(-16'sd2500);
    coef_we = 1'b0;
    check("wr_hs_err", longint'(coef_err), 1);
    wait_out("wr_hs", got);

    // Write during MAC is rejected and leaves the table alone
    send(16'sd300);
    repeat (5) tick();
    coef_we    = 1'b1;
    coef_addr  = 6'd10;
    coef_wdata = 16'sd12345;
    tick();
    coef_we = 1'b0;
    check("wr_mac_err", longint'(coef_err), 1);
    tick();
    check("wr_mac_err_pulse", longint'(coef_err), 0);
    wait_out("wr_mac", got);

    // Out-of-range address is rejected
    coef_we    = 1'b1;
    coef_addr  = 6'd51;
    coef_wdata = 16'sd777;
    tick();
    coef_we = 1'b0;
    check("wr_oob_err", longint'(coef_err), 1);
    send(16'sd123);
    wait_out("wr_oob", got);

    // Reset in the 20th MAC cycle aborts without emitting anything
    send(16'sd16384);
    repeat (19) tick();
    rst = 1'b0;
    #1;
    check("mid_rst_m_valid", longint'(m_valid), 0);
    check("mid_rst_m_data", longint'($signed(m_data)), 0);
    check("mid_rst_busy", longint'(busy), 0);
    check("mid_rst_s_ready", longint'(s_ready), 0);
    check("mid_rst_coef_err", longint'(coef_err), 0);
    tick();
    tick();
    check("mid_rst_hold_valid", longint'(m_valid), 0);
    rst = 1'b1;
    model_reset();
    for (int i = 0; i < NT; i++) begin
      send((i == 0) ? 16'sd16384 : 16'sd0);
      wait_out($sformatf("rimp%0d", i), got);
      if (i == 0)  check("rimp_first", got, -6);
      if (i == 25) check("rimp_centre", got, 14740);
      if (i == 50) check("rimp_last", got, -6);
    end

    // Accepted write: centre tap cleared, impulse shows zero at output 26
    coef_we    = 1'b1;
    coef_addr  = 6'd25;
    coef_wdata = 16'sd0;
    tick();
    coef_we = 1'b0;
    check("wr_ok_err", longint'(coef_err), 0);
    h_tb[25] = 0;
    for (int i = 0; i < 26; i++) begin
      send((i == 0) ? 16'sd16384 : 16'sd0);
      wait_out($sformatf("cimp%0d", i), got);
      if (i == 0)  check("cimp_first", got, -6);
      if (i == 25) check("cimp_centre", got, 0);
    end

    // Wrap: long run of varied samples against the golden convolution
    for (int i = 0; i < 120; i++) begin
      send(16'(i * 2749 + 333));
      wait_out($sformatf("wrap%0d", i), got);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fir_mac_scheduler.md
Name: fir_mac_scheduler

Overview:
Time-multiplexed controller for the 51-tap FIR high-pass datapath. It shares one multiplier and one accumulator across all taps instead of instantiating N parallel products.
- Accepts input samples over a valid/ready handshake and keeps history in a circular buffer.
- Sequences the MAC over every tap and returns the scaled result over a valid/ready handshake.
- Owns the runtime-writable coefficient memory, so the filter can be configured in place.

Parameters:
N, 51, tap count (odd, ≥3)
DATA_WIDTH, 16, sample width, signed
COEFF_WIDTH, 16, coefficient width, signed
ACC_WIDTH, 39, accumulator and output width (DATA_WIDTH+COEFF_WIDTH+7)
SHIFT, 15, arithmetic right shift applied to the accumulator at output

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-low (asserted at 0)
s_valid  input  1  input sample valid
s_ready  output  1  scheduler can accept a sample
s_data  input  DATA_WIDTH  signed input sample
m_valid  output  1  filter output valid
m_ready  input  1  downstream accepts output
m_data  output  ACC_WIDTH  signed filtered output
coef_we  input  1  coefficient write strobe
coef_addr  input  $clog2(N)  coefficient index
coef_wdata  input  COEFF_WIDTH  signed coefficient value
coef_err  output  1  one-cycle pulse: write rejected
busy  output  1  high in MAC or OUT state

Behaviour:
- Clock and reset: one clock domain. rst is asynchronous and active-low.
- Reset values: state=IDLE, s_ready=0 while rst=0, m_valid=0, m_data=0, coef_err=0, busy=0. Also cleared by reset: wr_ptr=0, tap counter=0, accumulator=0, all N history entries=0. Coefficients reload the default HPF table from the package.
- State IDLE:
  - s_ready=1.
  - On s_valid&s_ready: write s_data to hist[wr_ptr], clear accumulator, load tap k=0, go to MAC.
- State MAC:
  - One tap per cycle: acc += h[k]*hist[(wr_ptr−k) mod N]. The index wraps below 0 to N−1.
  - After k=N−1: wr_ptr advances, wrapping from N−1 to 0. Go to OUT.
  - MAC lasts exactly N cycles.
- State OUT:
  - m_valid=1 and m_data=acc>>>SHIFT (arithmetic, floor toward −∞).
  - m_data is held stable until m_ready. On m_valid&m_ready, go to IDLE.
- Latency: sample handshake at cycle 0, m_valid rises at cycle N+1 (52 at default). Maximum throughput is one sample per N+2 cycles.
- Arithmetic: product is COEFF_WIDTH+DATA_WIDTH bits, sign-extended into ACC_WIDTH. Accumulation never overflows for N≤64. No saturation.
- s_ready=0 in MAC and OUT. An s_valid in those states is not consumed and must be held by the source.
- Handshake completing in OUT with s_valid high: the sample is not accepted that cycle. It is accepted in IDLE on the following cycle.
- Coefficient writes:
  - Accepted only in IDLE when no sample handshake occurs in the same cycle; the write takes effect next cycle.
  - Writes in MAC or OUT, or coincident with a sample handshake, are dropped and coef_err pulses for one cycle.
  - coef_addr ≥ N is dropped and coef_err pulses.
- Reset mid-operation: asynchronous abort to the reset values above. A partial result is never emitted.

Optional Feature:
Macro SYMMETRIC_FOLD_EN.
- Defined:
  - MAC uses coefficient symmetry. For k<(N−1)/2: acc += h[k]*(hist[a_k]+hist[b_k]), with the pre-add at DATA_WIDTH+1 bits. a_k and b_k are the indices of taps k and N−1−k.
  - The centre tap is processed alone. MAC lasts (N+1)/2 cycles, and m_valid rises at cycle (N+1)/2+1 (27 at default).
  - A coefficient write to addr k also writes N−1−k.
- Undefined: the full N-cycle MAC described above. Writes affect only the addressed entry.
- Output values are identical in both builds while the coefficients are symmetric.

Decomposition:
- Package fir_sched_pkg holds:
  - state enum {IDLE, MAC, OUT}
  - default N, DATA_WIDTH, COEFF_WIDTH, ACC_WIDTH, SHIFT constants
  - default 51-entry HPF coefficient table: symmetric, centre 29480, sum −2
  - a modular-index helper function
- Natural sub-module: fir_coef_ram. It holds the coefficient register file, reset-load of defaults, write port with bounds check and optional mirror write, and the read port.

Test Plan:
- Impulse: s_data=16384, then 50 zeros, with default coefficients and m_ready=1. The k-th output is h[k]>>>1: first −6, 26th 14740, last −6. Each m_valid rises 52 cycles after its handshake.
- DC: constant s_data=1000 for 60 samples. From sample 51 onward, m_data=−1 (−2000>>>15).
- Backpressure: m_ready=0 for 10 cycles in OUT. m_valid and m_data stay stable, s_ready=0, and no sample is lost once m_ready=1.
- Coefficient write: coef_we in IDLE with addr 25 and value 0, then impulse 16384. The 26th output is 0. A write during MAC produces a coef_err pulse and leaves the table unchanged. addr=51 also produces coef_err.
- Reset mid-MAC: drive rst=0 at MAC cycle 20. All outputs clear immediately with no m_valid. The next impulse after release reproduces the impulse-test sequence.
- Wrap: 120 consecutive samples. The wr_ptr wrap from 50 to 0 produces outputs matching a golden convolution. Repeat with SYMMETRIC_FOLD_EN defined: identical data, latency 27.
